// File: rtl/rv32v_rob_wb_arbiter.sv
// Round-robin write-back arbiter from the vector FUs into the single ROB result port.
// Multi-beat bursts hold the grant via a lock; the output is a registered 1-deep stage.
module rv32v_rob_wb_arbiter #(
  parameter int N_REQ = 6,
  parameter int PW    = 96,
  parameter int ID_W  = 3
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               flush,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  input  logic [N_REQ*PW-1:0] req_payload,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [PW-1:0]      out_payload,
  output logic [ID_W-1:0]    out_src,
  output logic               out_last,
  input  logic               out_ready,
  output logic               locked
);

  logic              r_out_valid;
  logic [PW-1:0]     r_out_payload;
  logic [ID_W-1:0]   r_out_src;
  logic              r_out_last;
  logic              r_locked;
  logic [ID_W-1:0]   r_lock_id;
  logic [ID_W-1:0]   r_rr_ptr;

  logic              w_load_en;
  logic [N_REQ-1:0]  w_elig;
  logic              w_found_hi;
  logic              w_found_lo;
  logic [ID_W-1:0]   w_gnt_hi;
  logic [ID_W-1:0]   w_gnt_lo;
  logic              w_found;
  logic [ID_W-1:0]   w_gnt;
  logic [N_REQ-1:0]  w_gnt_oh;
  logic [PW-1:0]     w_gnt_payload;
  logic              w_gnt_last;
  logic              w_xfer;

  assign w_load_en = !flush && (!r_out_valid || out_ready);

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_elig[i] = req_valid[i] && (!r_locked || (r_lock_id == ID_W'(i)));
    end
  end

  // Descending scan leaves the lowest eligible index; the "hi" pick only considers
  // indices at or above rr_ptr, so it wins over the wrapped "lo" pick.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_gnt_hi   = '0;
    w_gnt_lo   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_found_lo = 1'b1;
        w_gnt_lo   = ID_W'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_found_hi = 1'b1;
          w_gnt_hi   = ID_W'(i);
        end
      end
    end
  end

  assign w_found = w_found_hi || w_found_lo;
  assign w_gnt   = w_found_hi ? w_gnt_hi : w_gnt_lo;
  assign w_xfer  = w_load_en && w_found && nRST;

  always_comb begin
    w_gnt_oh      = '0;
    w_gnt_payload = '0;
    w_gnt_last    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt == ID_W'(i)) begin
        w_gnt_oh[i]   = 1'b1;
        w_gnt_payload = req_payload[i*PW +: PW];
        w_gnt_last    = req_last[i];
      end
    end
  end

  assign req_ready = w_xfer ? w_gnt_oh : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_out_valid   <= 1'b0;
      r_out_payload <= '0;
      r_out_src     <= '0;
      r_out_last    <= 1'b0;
      r_locked      <= 1'b0;
      r_lock_id     <= '0;
      r_rr_ptr      <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_locked    <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid   <= 1'b1;
      r_out_payload <= w_gnt_payload;
      r_out_src     <= w_gnt;
      r_out_last    <= w_gnt_last;
      if (w_gnt_last) begin
        r_locked <= 1'b0;
        r_rr_ptr <= (w_gnt == ID_W'(N_REQ - 1)) ? '0 : w_gnt + ID_W'(1);
      end else begin
        r_locked  <= 1'b1;
        r_lock_id <= w_gnt;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_payload = r_out_payload;
  assign out_src     = r_out_src;
  assign out_last    = r_out_last;
  assign locked      = r_locked;

endmodule
